// File: rtl/game_round_ctrl_pkg.sv
// Shared game types: round states and field widths.
// The display logic decodes state_o through state_t.
package game_round_ctrl_pkg;

  localparam int SEC_W   = 6;
  localparam int SCORE_W = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } state_t;

  typedef logic [SEC_W-1:0]   sec_t;
  typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Bundle between the round controller and the rest of the game.
// master is the game side, slave is the round controller.
interface game_round_ctrl_if;
  import game_round_ctrl_pkg::*;

  logic   start;
  score_t score;
  logic   spawn_enable;
  logic   score_clear;
  sec_t   seconds_left;
  logic   round_done;
  score_t high_score;
  logic [1:0] state_o;

  modport master (
    output start, score,
    input  spawn_enable, score_clear,
    input  seconds_left, round_done,
    input  high_score, state_o
  );

  modport slave (
    input  start, score,
    output spawn_enable, score_clear,
    output seconds_left, round_done,
    output high_score, state_o
  );

endinterface

// File: rtl/game_round_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while run is high.
// tick marks the last count of each second.
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER,
// with seconds display and best-score tracking.
module game_round_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int ROUND_S     = 30,
  parameter int COUNTDOWN_S = 3
) (
  input logic clk,
  input logic reset,
  game_round_ctrl_if.slave bus
);
  import game_round_ctrl_pkg::*;

  localparam sec_t CD_LD = sec_t'(COUNTDOWN_S);
  localparam sec_t RS_LD = sec_t'(ROUND_S);

  state_t state, state_d;
  sec_t   secs, secs_d;
  score_t hs, hs_d;
  logic   spawn, spawn_d;
  logic   clr, clr_d;
  logic   done, done_d;
  logic   tick, fin, run, pre_clr;

  assign run = (state == COUNTDOWN) ||
               (state == PLAY);
  assign fin = tick && (secs == sec_t'(1));
  // Prescaler restarts on every COUNTDOWN entry and on PLAY entry.
  assign pre_clr = bus.start ||
                   (fin && state == COUNTDOWN);

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(pre_clr),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (bus.start) begin
      state_d = COUNTDOWN;
    end else if (fin) begin
      unique case (state)
        COUNTDOWN: state_d = PLAY;
        PLAY:      state_d = OVER;
        default:   state_d = state;
      endcase
    end
  end

  // start outranks the final tick, so an abort never scores.
  always_comb begin
    secs_d  = secs;
    hs_d    = hs;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    spawn_d = (state_d == PLAY);
    if (bus.start) begin
      secs_d = CD_LD;
      clr_d  = 1'b1;
    end else if (fin && state == COUNTDOWN) begin
      secs_d = RS_LD;
    end else if (fin && state == PLAY) begin
      secs_d = '0;
      done_d = 1'b1;
      if (bus.score > hs) hs_d = bus.score;
    end else if (tick) begin
      secs_d = secs - sec_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secs  <= '0;
      hs    <= '0;
      spawn <= 1'b0;
      clr   <= 1'b0;
      done  <= 1'b0;
    end else begin
      secs  <= secs_d;
      hs    <= hs_d;
      spawn <= spawn_d;
      clr   <= clr_d;
      done  <= done_d;
    end
  end

  assign bus.spawn_enable = spawn;
  assign bus.score_clear  = clr;
  assign bus.seconds_left = secs;
  assign bus.round_done   = done;
  assign bus.high_score   = hs;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed rounds plus random starts,
// checked against a time-since-start reference model.
module tb_game_round_ctrl;

  localparam int HZ   = 10;
  localparam int RS   = 5;
  localparam int CD   = 2;
  localparam int CD_L = CD * HZ;
  localparam int TOT  = CD_L + RS * HZ;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .CLK_HZ     (HZ),
    .ROUND_S    (RS),
    .COUNTDOWN_S(CD)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // model: cycles elapsed since the last start edge
  bit          active;
  int          t;
  logic [10:0] m_hs;
  bit          m_clr;
  bit          m_done;
  int          spawn_cnt;
  int          done_cnt;

  function automatic int exp_state();
    if (!active)       return 0;
    else if (t < CD_L) return 1;
    else if (t < TOT)  return 2;
    else               return 3;
  endfunction

  function automatic int exp_sec();
    case (exp_state())
      1:       return CD - t / HZ;
      2:       return RS - (t - CD_L) / HZ;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    active = 0;
    t      = 0;
    m_hs   = '0;
    m_clr  = 0;
    m_done = 0;
  endtask

  task automatic model_edge(input bit s,
                            input logic [10:0] sc);
    m_clr  = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (s) begin
      active = 1;
      t      = 0;
      m_clr  = 1;
    end else if (active && t <= TOT) begin
      t++;
      if (t == TOT) begin
        m_done = 1;
        if (sc > m_hs) m_hs = sc;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(bus.state_o), exp_state());
    chk("secs", 32'(bus.seconds_left), exp_sec());
    chk("spawn", 32'(bus.spawn_enable),
        32'(exp_state() == 2));
    chk("clear", 32'(bus.score_clear), 32'(m_clr));
    chk("done", 32'(bus.round_done), 32'(m_done));
    chk("hs", 32'(bus.high_score), 32'(m_hs));
  endtask

  task automatic step(input bit s,
                      input logic [10:0] sc);
    @(negedge clk);
    bus.start = s;
    bus.score = sc;
    @(posedge clk);
    model_edge(s, sc);
    #1;
    check_all();
  endtask

  task automatic run(input int n,
                     input logic [10:0] sc);
    for (int i = 0; i < n; i++) begin
      step(1'b0, sc);
      spawn_cnt += int'(bus.spawn_enable);
      done_cnt  += int'(bus.round_done);
    end
  endtask

  logic [10:0] rsc;

  initial begin
    bus.start = 1'b0;
    bus.score = '0;
    model_reset();
    spawn_cnt = 0;
    done_cnt  = 0;

    // reset values while reset is held
    step(1'b0, 11'd0);
    step(1'b0, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    run(3, 11'd0);

    // round 1: score 42
    spawn_cnt = 0;
    done_cnt  = 0;
    step(1'b1, 11'd42);
    chk("r1_clear", 32'(bus.score_clear), 1);
    chk("r1_cd_sec", 32'(bus.seconds_left), 2);
    run(19, 11'd42);
    chk("r1_cd_end", 32'(bus.state_o), 1);
    chk("r1_cd_sec1", 32'(bus.seconds_left), 1);
    run(1, 11'd42);
    chk("r1_play", 32'(bus.state_o), 2);
    chk("r1_play_sec", 32'(bus.seconds_left), 5);
    run(60, 11'd42);
    chk("r1_spawn_len", spawn_cnt, 50);
    chk("r1_done_cnt", done_cnt, 1);
    chk("r1_hs", 32'(bus.high_score), 42);

    // rounds 2 and 3: lower and equal scores
    step(1'b1, 11'd17);
    run(80, 11'd17);
    chk("r2_hs", 32'(bus.high_score), 42);
    step(1'b1, 11'd42);
    run(80, 11'd42);
    chk("r3_hs", 32'(bus.high_score), 42);

    // abort at PLAY cycle 23
    step(1'b1, 11'd99);
    run(20 + 23, 11'd99);
    done_cnt = 0;
    step(1'b1, 11'd99);
    chk("ab_state", 32'(bus.state_o), 1);
    chk("ab_clear", 32'(bus.score_clear), 1);
    run(5, 11'd99);
    chk("ab_done", done_cnt, 0);
    chk("ab_hs", 32'(bus.high_score), 42);

    // restart inside COUNTDOWN, then start on final tick
    step(1'b1, 11'd500);
    run(TOT - 1, 11'd500);
    chk("ft_pre", 32'(bus.seconds_left), 1);
    done_cnt = 0;
    step(1'b1, 11'd500);
    chk("ft_state", 32'(bus.state_o), 1);
    run(3, 11'd500);
    chk("ft_done", done_cnt, 0);
    chk("ft_hs", 32'(bus.high_score), 42);

    // random starts and scores
    rsc = 11'd0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0)
        rsc = 11'($urandom_range(0, 2047));
      step($urandom_range(0, 59) == 0, rsc);
    end

    // asynchronous reset mid-PLAY with score 99
    step(1'b1, 11'd99);
    run(CD_L + 10, 11'd99);
    chk("rp_play", 32'(bus.state_o), 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1'b0, 11'd99);
    @(negedge clk);
    rst = 1'b0;
    run(5, 11'd99);
    chk("rp_hs", 32'(bus.high_score), 0);
    chk("rp_idle", 32'(bus.state_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per one-second tick.
REQ-002 Parameter ROUND_S, default 30, play-phase length in seconds (1..63).
REQ-003 Parameter COUNTDOWN_S, default 3, pre-play countdown length in seconds (1..63).
REQ-004 clk  input  1  system clock; the only clock (CLOCK2_50 at top level).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse from the debounced KEY[0]; starts or restarts a round.
REQ-007 score  input  11  current score from score_counter.
REQ-008 spawn_enable  output  1  high only in PLAY; gates mole_control_fsm and hit scoring.
REQ-009 score_clear  output  1  single-cycle pulse; drives score_counter restart.
REQ-010 seconds_left  output  6  countdown value in COUNTDOWN, remaining round time in PLAY, 0 otherwise.
REQ-011 round_done  output  1  single-cycle pulse on PLAY to OVER.
REQ-012 high_score  output  11  best final score since reset.
REQ-013 state_o  output  2  current state encoding, for display and debug.

Function
REQ-014 The FSM SHALL have states IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3.
REQ-015 IDLE --start--> COUNTDOWN; OVER --start--> COUNTDOWN; PLAY --start--> COUNTDOWN (abort); a start in COUNTDOWN restarts the countdown from COUNTDOWN_S.
REQ-016 Each entry to COUNTDOWN SHALL pulse score_clear in the same cycle as the transition edge, zero the prescaler, and load seconds_left=COUNTDOWN_S.
REQ-017 Prescaler: 0..CLK_HZ-1 counter, active only in COUNTDOWN and PLAY; tick asserted when the count equals CLK_HZ-1, after which the count wraps to 0.
REQ-018 On each tick, seconds_left SHALL decrement by 1; a tick with seconds_left==1 SHALL cause the state transition instead of decrementing to 0.
REQ-019 COUNTDOWN, tick with seconds_left==1 -> PLAY, with seconds_left loaded to ROUND_S and the prescaler zeroed.
REQ-020 PLAY, tick with seconds_left==1 -> OVER, with seconds_left set to 0 and round_done pulsed for one cycle.
REQ-021 On entry to OVER, if score > high_score then high_score SHALL load score, sampled in the same cycle as round_done; equal scores do not update.
REQ-022 An aborted round (start in PLAY) SHALL NOT update high_score and SHALL NOT pulse round_done.
REQ-023 spawn_enable SHALL be a registered output, high exactly during cycles where state==PLAY.
REQ-024 A start coinciding with the final PLAY tick SHALL take priority: the FSM goes to COUNTDOWN, with no round_done pulse and no high_score update.
REQ-025 Round length from PLAY entry to round_done SHALL be exactly ROUND_S*CLK_HZ cycles.
REQ-026 seconds_left SHALL be 0 in IDLE and OVER.

Reset
REQ-027 While reset is high, outputs SHALL be: state=IDLE, prescaler=0, seconds_left=0, spawn_enable=0, score_clear=0, round_done=0, high_score=0.
REQ-028 Reset asserted mid-round SHALL abort immediately without updating high_score; after release the FSM waits in IDLE for start.

Structure
REQ-029 The state enum and the 6-bit seconds width SHALL live in the shared game package, so the display logic can decode state_o.
REQ-030 The prescaler SHALL be one sub-module, sec_tick_gen, with inputs clk, reset, clear and run, and output tick.
REQ-031 The FSM, seconds counter and high-score register SHALL stay in game_round_ctrl; the block SHALL contain no combinational output paths.

Verification (CLK_HZ=10, ROUND_S=5, COUNTDOWN_S=2)
REQ-032 Start pulse from IDLE -> score_clear pulses once; seconds_left shows 2, then 1; PLAY is entered 20 cycles later with seconds_left=5.
REQ-033 Full round with score held at 42 -> round_done pulses 50 cycles after PLAY entry; high_score=42; spawn_enable is high for exactly 50 cycles.
REQ-034 Second round ending with score 17 -> high_score stays 42; a third round ending with score 42 -> high_score stays 42.
REQ-035 Start pulse at PLAY cycle 23 -> COUNTDOWN next cycle; score_clear pulses; no round_done; high_score is unchanged.
REQ-036 Start coincident with the final PLAY tick -> COUNTDOWN; no round_done pulse.
REQ-037 Reset asserted in PLAY with score 99 -> all outputs go to their REQ-027 values asynchronously; high_score=0 after release.
